updown_step_ctrl: RTL and testbench

//  Sequencer for the synchronous 3-bit up/down JK counter datapath (Syn_UP_DOWN style).

---
 rtl/updown_step_ctrl.sv | 128 ++++++++++++
 tb/tb_updown_step_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_step_ctrl.sv
// Step sequencer for an up/down counter: accepts "move N steps" commands, drives mode M and step enable.
// Latency accept+1+N+1 cycles; cmd_ready only in IDLE, so a held cmd_valid waits out SETUP/STEP/DONE.
module updown_step_ctrl #(
    parameter int CNT_W  = 3,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_wrap,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cnt_q,
    output logic              cnt_m,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done,
    output logic              limit_hit,
    output logic              aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              dir_q, dir_d;
    logic              wrap_q, wrap_d;
    logic              cnt_m_q, cnt_m_d;
    logic [STEP_W-1:0] steps_done_q, steps_done_d;
    logic              limit_hit_q, limit_hit_d;
    logic              aborted_q, aborted_d;
    logic              at_lim;
    logic              step_ok;

    assign at_lim = dir_q ? (cnt_q == {CNT_W{1'b1}}) : (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        wrap_d       = wrap_q;
        cnt_m_d      = cnt_m_q;
        steps_done_d = steps_done_q;
        limit_hit_d  = limit_hit_q;
        aborted_d    = aborted_q;
        step_ok      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rem_d        = cmd_steps;
                    dir_d        = cmd_dir;
                    wrap_d       = cmd_wrap;
                    cnt_m_d      = cmd_dir;
                    steps_done_d = '0;
                    limit_hit_d  = 1'b0;
                    aborted_d    = 1'b0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = (rem_q == '0) ? DONE : STEP;
            end
            STEP: begin
                step_ok = (rem_q != '0) & ~abort & ~(at_lim & ~wrap_q);
                if (step_ok) begin
                    rem_d        = rem_q - STEP_W'(1);
                    steps_done_d = steps_done_q + STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = DONE;
                    end
                end
                // A denied step at a boundary and an abort may coincide; report both.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end
                if (at_lim & ~wrap_q & (rem_q != '0)) begin
                    limit_hit_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            wrap_q       <= 1'b0;
            cnt_m_q      <= 1'b1;
            steps_done_q <= '0;
            limit_hit_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            wrap_q       <= wrap_d;
            cnt_m_q      <= cnt_m_d;
            steps_done_q <= steps_done_d;
            limit_hit_q  <= limit_hit_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE) & clear;
    assign cnt_m      = cnt_m_q;
    assign cnt_en     = step_ok;
    assign busy       = (state_q == SETUP) | (state_q == STEP);
    assign done       = (state_q == DONE);
    assign steps_done = steps_done_q;
    assign limit_hit  = limit_hit_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Directed bench for updown_step_ctrl with a behavioural 3-bit up/down counter closing the cnt_q loop.
module tb_updown_step_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_steps;
    logic       cmd_wrap;
    logic       abort;
    logic [2:0] cnt_q;
    logic       cnt_m;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic [3:0] steps_done;
    logic       limit_hit;
    logic       aborted;

    int vectors = 0;
    int miscompares = 0;
    int en_count = 0;
    int done_seen = 0;

    updown_step_ctrl #(.CNT_W(3), .STEP_W(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_wrap   (cmd_wrap),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_m      (cnt_m),
        .cnt_en     (cnt_en),
        .busy       (busy),
        .done       (done),
        .steps_done (steps_done),
        .limit_hit  (limit_hit),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    // Counter datapath model: advances on edges where cnt_en is high, direction from cnt_m.
    always @(posedge clk) begin
        if (cnt_en) begin
            cnt_q <= cnt_m ? cnt_q + 3'd1 : cnt_q - 3'd1;
            en_count = en_count + 1;
        end
        if (done) done_seen = done_seen + 1;
    end

    // Offers one command for one cycle; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic d, input logic [3:0] s, input logic w, input logic [2:0] c);
        @(negedge clk);
        cnt_q     = c;
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = s;
        cmd_wrap  = w;
        en_count  = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Cycles from SETUP until done is seen, or -1 if the bound expires.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        clear = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        cmd_wrap = 1'b0; abort = 1'b0; cnt_q = 3'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cnt_m, cnt_en, busy, done, steps_done, limit_hit, aborted} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs got m=%b en=%b busy=%b done=%b sd=%0d lh=%b ab=%b exp m=1 others 0",
                     cnt_m, cnt_en, busy, done, steps_done, limit_hit, aborted);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low got %b exp 0", cmd_ready);
        end
        clear = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_high got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid_step;
        int seen0;
        issue(1'b0, 4'd5, 1'b0, 3'd6);
        @(negedge clk);
        @(negedge clk);
        seen0 = done_seen;
        clear = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cnt_m, cnt_en, busy, done, steps_done, limit_hit, aborted, cmd_ready} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midstep_reset got m=%b en=%b busy=%b done=%b sd=%0d lh=%b ab=%b rdy=%b exp m=1 others 0",
                     cnt_m, cnt_en, busy, done, steps_done, limit_hit, aborted, cmd_ready);
        end
        clear = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midstep_ready got %b exp 1", cmd_ready);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (done_seen !== seen0) begin
            miscompares++;
            $display("FAIL midstep_no_done got %0d pulses exp 0", done_seen - seen0);
        end
    endtask

    task automatic test_up_plain;
        int cyc;
        issue(1'b1, 4'd3, 1'b0, 3'd2);
        wait_done(cyc);
        vectors++;
        if (cyc !== 4 || en_count !== 3 || cnt_q !== 3'd5) begin
            miscompares++;
            $display("FAIL up_plain got cyc=%0d en=%0d cnt=%0d exp cyc=4 en=3 cnt=5", cyc, en_count, cnt_q);
        end
        vectors++;
        if (steps_done !== 4'd3 || limit_hit !== 1'b0 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL up_plain_flags got sd=%0d lh=%b ab=%b exp 3 0 0", steps_done, limit_hit, aborted);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || steps_done !== 4'd3 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL up_plain_hold got done=%b sd=%0d rdy=%b exp 0 3 1", done, steps_done, cmd_ready);
        end
    endtask

    task automatic test_saturate;
        int cyc;
        issue(1'b1, 4'd6, 1'b0, 3'd5);
        wait_done(cyc);
        vectors++;
        if (cyc !== 4 || en_count !== 2 || cnt_q !== 3'd7 || steps_done !== 4'd2 || limit_hit !== 1'b1 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate got cyc=%0d en=%0d cnt=%0d sd=%0d lh=%b ab=%b exp 4 2 7 2 1 0",
                     cyc, en_count, cnt_q, steps_done, limit_hit, aborted);
        end
        // Landing on the boundary with the final step is not a limit hit.
        issue(1'b1, 4'd3, 1'b0, 3'd4);
        wait_done(cyc);
        vectors++;
        if (cnt_q !== 3'd7 || steps_done !== 4'd3 || limit_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL land_on_max got cnt=%0d sd=%0d lh=%b exp 7 3 0", cnt_q, steps_done, limit_hit);
        end
    endtask

    task automatic test_wrap_down;
        int cyc;
        int m_bad;
        issue(1'b0, 4'd4, 1'b1, 3'd1);
        m_bad = 0;
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (cnt_m !== 1'b0) m_bad++;
            if (done) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (cyc !== 5 || en_count !== 4 || cnt_q !== 3'd5 || m_bad !== 0) begin
            miscompares++;
            $display("FAIL wrap_down got cyc=%0d en=%0d cnt=%0d m_bad=%0d exp 5 4 5 0", cyc, en_count, cnt_q, m_bad);
        end
        vectors++;
        if (steps_done !== 4'd4 || limit_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_down_flags got sd=%0d lh=%b exp 4 0", steps_done, limit_hit);
        end
    endtask

    task automatic test_zero_steps;
        int cyc;
        issue(1'b1, 4'd0, 1'b0, 3'd3);
        vectors++;
        if (busy !== 1'b1 || cnt_en !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_setup got busy=%b en=%b done=%b exp 1 0 0", busy, cnt_en, done);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 1 || en_count !== 0 || steps_done !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_steps got cyc=%0d en=%0d sd=%0d busy=%b exp 1 0 0 0", cyc, en_count, steps_done, busy);
        end
    endtask

    task automatic test_abort;
        issue(1'b1, 4'd5, 1'b0, 3'd0);
        abort = 1'b1;
        #1;
        vectors++;
        if (cnt_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_in_setup got en=%b busy=%b exp 0 1", cnt_en, busy);
        end
        abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        vectors++;
        if (cnt_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_step got en=%b exp 0", cnt_en);
        end
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (done !== 1'b1 || aborted !== 1'b1 || steps_done !== 4'd1 || limit_hit !== 1'b0 || en_count !== 1 || cnt_q !== 3'd1) begin
            miscompares++;
            $display("FAIL abort_done got done=%b ab=%b sd=%0d lh=%b en=%0d cnt=%0d exp 1 1 1 0 1 1",
                     done, aborted, steps_done, limit_hit, en_count, cnt_q);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(1'b1, 4'd1, 1'b0, 3'd3);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || cnt_m !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_in_done got done=%b rdy=%b m=%b exp 1 0 1", done, cmd_ready, cnt_m);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || cnt_m !== 1'b1 || busy !== 1'b0 || cnt_q !== 3'd4) begin
            miscompares++;
            $display("FAIL b2b_idle got rdy=%b m=%b busy=%b cnt=%0d exp 1 1 0 4", cmd_ready, cnt_m, busy, cnt_q);
        end
        en_count = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (cnt_m !== 1'b0 || cnt_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_setup got m=%b en=%b busy=%b exp 0 0 1", cnt_m, cnt_en, busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 2 || cnt_q !== 3'd3 || steps_done !== 4'd1 || en_count !== 1) begin
            miscompares++;
            $display("FAIL b2b_second got cyc=%0d cnt=%0d sd=%0d en=%0d exp 2 3 1 1", cyc, cnt_q, steps_done, en_count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_step();
        test_up_plain();
        test_saturate();
        test_wrap_down();
        test_zero_steps();
        test_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
